// File: rtl/ap_ctrl_sequencer_pkg.sv
// ap_seq_pkg: shared state encoding, default sizing and a sizing helper for the ap_ctrl_hs sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ap_seq_pkg;

    localparam int DEF_CNT_W        = 32;
    localparam int DEF_MAX_INFLIGHT = 2;
    localparam int DEF_TIMEOUT_CYC  = 100000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FINISH = 3'd3,
        ST_ABORT  = 3'd4
    } seq_state_e;

    // Bits needed for an occupancy count covering 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ap_ctrl_sequencer_if.sv
// ap_ctrl_sequencer_if: run-control, ap_ctrl_hs handshake and status bundle of the sequencer.
// Latency: n/a (wires only).
// Backpressure: ap_ready/ap_done from the kernel side; master = sequencer, slave = kernel/host side.
//
// Signals:
//   cfg_go, cfg_num_txn         host -> sequencer, run start pulse and transaction count
//   ap_start, ap_continue       sequencer -> kernel
//   ap_ready, ap_done           kernel -> sequencer
//   busy, finish, timeout, spurious, start_cnt, done_cnt, lat_last, lat_max   sequencer status
interface ap_ctrl_sequencer_if
    import ap_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             cfg_go;
    logic [CNT_W-1:0] cfg_num_txn;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             busy;
    logic             finish;
    logic             timeout;
    logic             spurious;
    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [CNT_W-1:0] lat_last;
    logic [CNT_W-1:0] lat_max;

    modport master (
        input  cfg_go, cfg_num_txn, ap_ready, ap_done,
        output ap_start, ap_continue, busy, finish, timeout, spurious,
               start_cnt, done_cnt, lat_last, lat_max
    );

    modport slave (
        output cfg_go, cfg_num_txn, ap_ready, ap_done,
        input  ap_start, ap_continue, busy, finish, timeout, spurious,
               start_cnt, done_cnt, lat_last, lat_max
    );

endinterface

// File: rtl/ap_ctrl_sequencer_ts_fifo.sv
// ap_seq_ts_fifo: start-timestamp FIFO, one entry per accepted-but-not-completed transaction.
// Latency: head visible combinationally; push+pop on an empty FIFO bypasses i_push_dat to o_pop_dat.
// Backpressure: none internally; the caller must never push when full (inflight gating guarantees it).
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset (flushes)
//   i_flush                 synchronous flush at run start
//   i_push, i_push_dat      write a timestamp
//   i_pop, o_pop_dat        consume head (or the bypassed push data when empty)
//   o_empty, o_full         occupancy flags
module ap_seq_ts_fifo
    import ap_seq_pkg::*;
#(
    parameter int DAT_W = DEF_CNT_W,
    parameter int DEPTH = DEF_MAX_INFLIGHT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [DAT_W-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [DAT_W-1:0] o_pop_dat,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = occ_width(DEPTH);

    logic [DAT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    logic w_bypass;
    logic w_wr;
    logic w_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == OCC_W'(DEPTH));

    // Pushing and popping an empty FIFO in one cycle: the new timestamp is
    // consumed immediately and never stored.
    assign w_bypass  = i_push && i_pop && o_empty;
    assign w_wr      = i_push && !w_bypass;
    assign w_rd      = i_pop && !o_empty;
    assign o_pop_dat = o_empty ? i_push_dat : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: issues a programmed number of ap_ctrl_hs starts, tracks in-flight work, measures latency.
// Latency: ap_start is registered (one cycle after cfg_go / after the gating condition allows it).
// Backpressure: ap_start holds until ap_ready; at most MAX_INFLIGHT accepted-but-not-done transactions.
//
// Ports:
//   i_clk        single clock, rising edge
//   i_rst        asynchronous active-high reset; returns every output to 0
//   io_bus       master side of ap_ctrl_sequencer_if: cfg_go/cfg_num_txn in, ap_start/ap_continue out,
//                ap_ready/ap_done in, status out (busy, finish, timeout, spurious, counters, latencies)
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ap_ctrl_sequencer_if.master io_bus
);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_ISSUE  = 3'(ST_ISSUE);
    localparam logic [2:0] S_DRAIN  = 3'(ST_DRAIN);
    localparam logic [2:0] S_FINISH = 3'(ST_FINISH);
    localparam logic [2:0] S_ABORT  = 3'(ST_ABORT);

    localparam int              IF_W    = occ_width(MAX_INFLIGHT);
    localparam logic [IF_W-1:0] IF_MAX  = IF_W'(MAX_INFLIGHT);
    // The watchdog aborts on the TIMEOUT_CYC-th consecutive idle cycle, i.e.
    // when the count of earlier idle cycles is TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_start_cnt;
    logic [CNT_W-1:0] r_done_cnt;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_wdog;
    logic [CNT_W-1:0] r_lat_last;
    logic [CNT_W-1:0] r_lat_max;
    logic [IF_W-1:0]  r_inflight;
    logic             r_ap_start;
    logic             r_timeout;
    logic             r_spurious;

    logic             w_busy;
    logic             w_go;
    logic             w_accept;
    logic             w_done_ok;
    logic             w_spur;
    logic             w_wdog_hit;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_ap_start_nxt;
    logic [CNT_W-1:0] w_head;
    logic [CNT_W-1:0] w_lat;
    logic [CNT_W-1:0] w_start_cnt_nxt;
    logic [IF_W-1:0]  w_inflight_nxt;

    assign w_busy   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_go     = io_bus.cfg_go && !w_busy;
    assign w_accept = r_ap_start && io_bus.ap_ready;

    // A completion needs something to retire: a stored timestamp, or the one
    // being accepted in this very cycle (FIFO bypass).
    assign w_done_ok = io_bus.ap_done && w_busy && (!w_fifo_empty || w_accept);
    assign w_spur    = io_bus.ap_done && !w_done_ok;

    // Modular subtraction keeps latency correct across cycle-counter wrap.
    assign w_lat = r_cyc - w_head;

    assign w_wdog_hit = w_busy && !w_accept && !w_done_ok && (r_wdog == WD_LAST);

    assign w_start_cnt_nxt = r_start_cnt + (w_accept ? CNT_W'(1) : '0);

    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_accept, w_done_ok})
            2'b10:   w_inflight_nxt = r_inflight + IF_W'(1);
            2'b01:   w_inflight_nxt = r_inflight - IF_W'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_FINISH, S_ABORT: begin
                if (io_bus.cfg_go) begin
                    w_state_nxt = (io_bus.cfg_num_txn == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_wdog_hit) begin
                    w_state_nxt = S_ABORT;
                end else if (w_accept && (w_start_cnt_nxt == r_num)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (r_done_cnt == r_num) begin
                    w_state_nxt = S_FINISH;
                end else if (w_wdog_hit) begin
                    w_state_nxt = S_ABORT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ap_start is computed from next-cycle values so it is a clean register.
    // start_cnt only grows and inflight only grows on accept, so once asserted
    // it cannot drop before the kernel takes it (except on watchdog abort).
    always_comb begin
        w_ap_start_nxt = 1'b0;
        if (w_go) begin
            w_ap_start_nxt = (io_bus.cfg_num_txn != '0);
        end else begin
            w_ap_start_nxt = (w_state_nxt == S_ISSUE) &&
                             (w_start_cnt_nxt < r_num) &&
                             (w_inflight_nxt < IF_MAX);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_start_cnt <= '0;
            r_done_cnt  <= '0;
            r_cyc       <= '0;
            r_wdog      <= '0;
            r_lat_last  <= '0;
            r_lat_max   <= '0;
            r_inflight  <= '0;
            r_ap_start  <= 1'b0;
            r_timeout   <= 1'b0;
            r_spurious  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= r_cyc + CNT_W'(1);
            r_ap_start <= w_ap_start_nxt;
            if (w_go) begin
                r_num       <= io_bus.cfg_num_txn;
                r_start_cnt <= '0;
                r_done_cnt  <= '0;
                r_wdog      <= '0;
                r_lat_last  <= '0;
                r_lat_max   <= '0;
                r_inflight  <= '0;
                r_timeout   <= 1'b0;
                // A stray ap_done coinciding with the go pulse still counts for the new run.
                r_spurious  <= w_spur;
            end else begin
                r_start_cnt <= w_start_cnt_nxt;
                r_inflight  <= w_inflight_nxt;
                if (w_done_ok) begin
                    r_done_cnt <= r_done_cnt + CNT_W'(1);
                    r_lat_last <= w_lat;
                    if (w_lat > r_lat_max) begin
                        r_lat_max <= w_lat;
                    end
                end
                if (!w_busy || w_accept || w_done_ok) begin
                    r_wdog <= '0;
                end else begin
                    r_wdog <= r_wdog + CNT_W'(1);
                end
                if (w_wdog_hit && (w_state_nxt == S_ABORT)) begin
                    r_timeout <= 1'b1;
                end
                if (w_spur) begin
                    r_spurious <= 1'b1;
                end
            end
        end
    end

    ap_seq_ts_fifo #(
        .DAT_W (CNT_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_ts_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (w_go),
        .i_push     (w_accept),
        .i_push_dat (r_cyc),
        .i_pop      (w_done_ok),
        .o_pop_dat  (w_head),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    // The inflight gate on ap_start must keep the timestamp FIFO from overflowing.
    a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
        w_accept |-> !w_fifo_full);

    assign io_bus.ap_start    = r_ap_start;
    assign io_bus.ap_continue = w_busy;
    assign io_bus.busy        = w_busy;
    assign io_bus.finish      = (r_state == S_FINISH) || (r_state == S_ABORT);
    assign io_bus.timeout     = r_timeout;
    assign io_bus.spurious    = r_spurious;
    assign io_bus.start_cnt   = r_start_cnt;
    assign io_bus.done_cnt    = r_done_cnt;
    assign io_bus.lat_last    = r_lat_last;
    assign io_bus.lat_max     = r_lat_max;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// tb_ap_ctrl_sequencer: directed, table-driven bench for ap_ctrl_sequencer with a small kernel model.
// Latency: n/a.
// Backpressure: kernel model withholds ap_ready / delays ap_done per scenario.
module tb_ap_ctrl_sequencer;

    localparam int CNT_W   = 32;
    localparam int MAX_INF = 2;
    localparam int TO_CYC  = 50;

    logic clk;
    logic rst;
    int   edge_n;
    int   n_chk;
    int   n_fail;
    int   gate_viol;

    ap_ctrl_sequencer_if #(.CNT_W(CNT_W)) sq ();

    ap_ctrl_sequencer #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INF),
        .TIMEOUT_CYC  (TO_CYC)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (sq.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation still running, expected to finish");
        $fatal(1);
    end

    typedef struct {
        int unsigned num;
        int          rd;
        int          dd;
        int unsigned exp_start;
        int unsigned exp_done;
        int unsigned exp_lat_last;
        int unsigned exp_lat_max;
        logic        exp_finish;
        logic        exp_spur;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_go(input int unsigned num);
        sq.cfg_go      = 1'b1;
        sq.cfg_num_txn = num;
        tick();
        sq.cfg_go      = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ap_start"}, 32'(sq.ap_start), 0);
        chk({tag, "_ap_continue"}, 32'(sq.ap_continue), 0);
        chk({tag, "_busy"}, 32'(sq.busy), 0);
        chk({tag, "_finish"}, 32'(sq.finish), 0);
        chk({tag, "_timeout"}, 32'(sq.timeout), 0);
        chk({tag, "_spurious"}, 32'(sq.spurious), 0);
        chk({tag, "_start_cnt"}, sq.start_cnt, 0);
        chk({tag, "_done_cnt"}, sq.done_cnt, 0);
        chk({tag, "_lat_last"}, sq.lat_last, 0);
        chk({tag, "_lat_max"}, sq.lat_max, 0);
    endtask

    // Kernel: raises ap_ready once ap_start has been waiting rd cycles, and
    // raises ap_done exactly dd cycles after each accept. Runs until finish.
    task automatic run_kernel(input int rd, input int dd, input int budget, output bit ok);
        int age;
        int mif;
        int due[$];
        bit rdy;
        bit dn;
        bit st;
        age = 0;
        mif = 0;
        ok  = 1'b0;
        for (int n = 0; n < budget; n++) begin
            st  = sq.ap_start;
            rdy = st && (age >= rd);
            dn  = (due.size() > 0) && (due[0] == edge_n + 1);
            if (st && (mif >= MAX_INF)) gate_viol++;
            sq.ap_ready = rdy;
            sq.ap_done  = dn;
            tick();
            if (rdy) begin
                due.push_back(edge_n + dd);
                age = 0;
                mif++;
            end else if (st) begin
                age++;
            end
            if (dn) begin
                void'(due.pop_front());
                mif--;
            end
            sq.ap_ready = 1'b0;
            sq.ap_done  = 1'b0;
            if (sq.finish) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        n_chk     = 0;
        n_fail    = 0;
        edge_n    = 0;
        gate_viol = 0;

        vecs[0] = '{num: 3, rd: 1, dd: 5, exp_start: 3, exp_done: 3, exp_lat_last: 5, exp_lat_max: 5,
                    exp_finish: 1'b1, exp_spur: 1'b0};
        vecs[1] = '{num: 1, rd: 0, dd: 2, exp_start: 1, exp_done: 1, exp_lat_last: 2, exp_lat_max: 2,
                    exp_finish: 1'b1, exp_spur: 1'b0};
        vecs[2] = '{num: 5, rd: 0, dd: 1, exp_start: 5, exp_done: 5, exp_lat_last: 1, exp_lat_max: 1,
                    exp_finish: 1'b1, exp_spur: 1'b0};
        vecs[3] = '{num: 4, rd: 2, dd: 7, exp_start: 4, exp_done: 4, exp_lat_last: 7, exp_lat_max: 7,
                    exp_finish: 1'b1, exp_spur: 1'b0};

        rst            = 1'b1;
        sq.cfg_go      = 1'b0;
        sq.cfg_num_txn = '0;
        sq.ap_ready    = 1'b0;
        sq.ap_done     = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // ap_done while idle: spurious, nothing counted.
        sq.ap_done = 1'b1;
        tick();
        sq.ap_done = 1'b0;
        chk("idle_done_spurious", 32'(sq.spurious), 1);
        chk("idle_done_cnt", sq.done_cnt, 0);

        // num == 0: straight to finish, no start, flags cleared.
        do_go(0);
        chk("num0_finish", 32'(sq.finish), 1);
        chk("num0_busy", 32'(sq.busy), 0);
        chk("num0_spur_cleared", 32'(sq.spurious), 0);
        for (int i = 0; i < 4; i++) begin
            chk("num0_no_start", 32'(sq.ap_start), 0);
            tick();
        end

        // Table-driven complete runs.
        for (int v = 0; v < 4; v++) begin
            do_go(vecs[v].num);
            chk($sformatf("v%0d_busy", v), 32'(sq.busy), 1);
            chk($sformatf("v%0d_finish_low", v), 32'(sq.finish), 0);
            run_kernel(vecs[v].rd, vecs[v].dd, 300, ok);
            chk($sformatf("v%0d_reached_finish", v), 32'(ok), 1);
            chk($sformatf("v%0d_finish", v), 32'(sq.finish), 32'(vecs[v].exp_finish));
            chk($sformatf("v%0d_start_cnt", v), sq.start_cnt, vecs[v].exp_start);
            chk($sformatf("v%0d_done_cnt", v), sq.done_cnt, vecs[v].exp_done);
            chk($sformatf("v%0d_lat_last", v), sq.lat_last, vecs[v].exp_lat_last);
            chk($sformatf("v%0d_lat_max", v), sq.lat_max, vecs[v].exp_lat_max);
            chk($sformatf("v%0d_spurious", v), 32'(sq.spurious), 32'(vecs[v].exp_spur));
            chk($sformatf("v%0d_continue_off", v), 32'(sq.ap_continue), 0);
        end
        chk("inflight_gate_violations", 32'(gate_viol), 0);

        // ap_ready withheld for 10 cycles: ap_start must stay up, no accept.
        do_go(4);
        chk("hold_start_up", 32'(sq.ap_start), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold_start_c%0d", i), 32'(sq.ap_start), 1);
            chk($sformatf("hold_cnt_c%0d", i), sq.start_cnt, 0);
        end
        run_kernel(0, 3, 300, ok);
        chk("hold_reached_finish", 32'(ok), 1);
        chk("hold_done_cnt", sq.done_cnt, 4);
        chk("hold_lat_max", sq.lat_max, 3);

        // Same-cycle accept+completion: first with empty FIFO (bypass), then
        // accept of #3 together with done of #2.
        do_go(3);
        sq.ap_ready = 1'b1;
        sq.ap_done  = 1'b1;
        tick();
        chk("byp_start_cnt", sq.start_cnt, 1);
        chk("byp_done_cnt", sq.done_cnt, 1);
        chk("byp_lat_last", sq.lat_last, 0);
        chk("byp_spurious", 32'(sq.spurious), 0);
        chk("byp_start_still", 32'(sq.ap_start), 1);
        sq.ap_done = 1'b0;
        tick();
        chk("byp_start_cnt2", sq.start_cnt, 2);
        sq.ap_done = 1'b1;
        tick();
        chk("ovl_start_cnt", sq.start_cnt, 3);
        chk("ovl_done_cnt", sq.done_cnt, 2);
        chk("ovl_lat_last", sq.lat_last, 1);
        chk("ovl_ap_start_off", 32'(sq.ap_start), 0);
        chk("ovl_spurious", 32'(sq.spurious), 0);
        sq.ap_ready = 1'b0;
        tick();
        sq.ap_done = 1'b0;
        chk("ovl_done_cnt3", sq.done_cnt, 3);
        tick();
        chk("ovl_finish", 32'(sq.finish), 1);
        chk("ovl_lat_max", sq.lat_max, 1);

        // Watchdog: one accept, then the kernel never completes.
        do_go(1);
        sq.ap_ready = 1'b1;
        tick();
        sq.ap_ready = 1'b0;
        chk("wd_accepted", sq.start_cnt, 1);
        for (int i = 0; i < TO_CYC - 1; i++) tick();
        chk("wd_not_yet", 32'(sq.timeout), 0);
        chk("wd_busy_before", 32'(sq.busy), 1);
        tick();
        chk("wd_timeout", 32'(sq.timeout), 1);
        chk("wd_finish", 32'(sq.finish), 1);
        chk("wd_ap_start", 32'(sq.ap_start), 0);
        chk("wd_continue", 32'(sq.ap_continue), 0);
        do_go(1);
        chk("wd_go_clr_timeout", 32'(sq.timeout), 0);
        chk("wd_go_clr_finish", 32'(sq.finish), 0);
        run_kernel(0, 2, 300, ok);
        chk("wd_rerun_finish", 32'(ok), 1);
        chk("wd_rerun_done", sq.done_cnt, 1);

        // Reset in DRAIN with two in flight, then a clean run.
        do_go(2);
        sq.ap_ready = 1'b1;
        tick();
        tick();
        sq.ap_ready = 1'b0;
        chk("rst_pre_start_cnt", sq.start_cnt, 2);
        chk("rst_pre_busy", 32'(sq.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0;
        do_go(1);
        sq.ap_done = 1'b1;
        tick();
        sq.ap_done = 1'b0;
        chk("post_rst_fifo_empty_spur", 32'(sq.spurious), 1);
        chk("post_rst_done_cnt0", sq.done_cnt, 0);
        sq.ap_ready = 1'b1;
        tick();
        sq.ap_ready = 1'b0;
        chk("post_rst_start_cnt", sq.start_cnt, 1);
        tick();
        tick();
        tick();
        sq.ap_done = 1'b1;
        tick();
        sq.ap_done = 1'b0;
        chk("post_rst_done_cnt", sq.done_cnt, 1);
        chk("post_rst_lat_last", sq.lat_last, 4);
        tick();
        chk("post_rst_finish", 32'(sq.finish), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
